// File: rtl/lector_sensor_temp.sv
// lector_sensor_temp: periodic / on-demand reader for a serial temperature
// sensor. Clocks out a 16-bit frame, converts the 13-bit raw reading
// (1/16 degC) to tenths of degC, and clamps the result to a signed 11-bit range.

module lector_sensor_temp #(
  parameter int unsigned DIV_SCLK         = 4,
  parameter int unsigned PERIODO_MUESTREO = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iniciar,
  input  logic               sdo,
  output logic               sclk,
  output logic               cs_n,
  output logic signed [10:0] temp_entrada,
  output logic               dato_valido,
  output logic               saturado,
  output logic               ocupado
);

  typedef enum logic [1:0] {
    REPOSO,
    SELECCION,
    TRANSFERENCIA,
    CONVERSION
  } estado_t;

  estado_t            state_q, state_d;
  logic [31:0]        timer_q, timer_d;
  logic [7:0]         div_cnt_q, div_cnt_d;
  logic [4:0]         half_cnt_q, half_cnt_d;
  logic [15:0]        shift_q, shift_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic signed [10:0] temp_q, temp_d;
  logic               valido_q, valido_d;
  logic               sat_q, sat_d;
  logic               ocupado_q, ocupado_d;

  logic signed [16:0] raw_ext;
  logic signed [16:0] prod;
  logic signed [16:0] t_full;

  // Raw-to-tenths conversion: raw*10 as two shifts, then floor-divide by 16.
  always_comb begin
    raw_ext = {{4{shift_q[15]}}, shift_q[15:3]};
    prod    = (raw_ext <<< 3) + (raw_ext <<< 1);
    t_full  = prod >>> 4;
  end

  // Next-state and next-output logic; every output is computed one cycle ahead.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    div_cnt_d  = div_cnt_q;
    half_cnt_d = half_cnt_q;
    shift_d    = shift_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    temp_d     = temp_q;
    valido_d   = 1'b0;
    sat_d      = sat_q;
    ocupado_d  = ocupado_q;

    case (state_q)
      REPOSO: begin
        if ((timer_q == PERIODO_MUESTREO - 1) || iniciar) begin
          state_d   = SELECCION;
          timer_d   = 32'd0;
          div_cnt_d = 8'd0;
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
          ocupado_d = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      SELECCION: begin
        if (div_cnt_q == 8'(DIV_SCLK - 1)) begin
          state_d    = TRANSFERENCIA;
          div_cnt_d  = 8'd0;
          half_cnt_d = 5'd0;
          sclk_d     = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      TRANSFERENCIA: begin
        if (div_cnt_q == 8'(DIV_SCLK - 1)) begin
          div_cnt_d = 8'd0;
          if (half_cnt_q == 5'd31) begin
            state_d = CONVERSION;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
          end else begin
            half_cnt_d = half_cnt_q + 5'd1;
            sclk_d     = ~sclk_q;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      CONVERSION: begin
        state_d   = REPOSO;
        timer_d   = 32'd0;
        ocupado_d = 1'b0;
        valido_d  = 1'b1;
        if (t_full > 17'sd1023) begin
          temp_d = 11'sd1023;
          sat_d  = 1'b1;
        end else if (t_full < -17'sd1024) begin
          temp_d = -11'sd1024;
          sat_d  = 1'b1;
        end else begin
          temp_d = signed'(t_full[10:0]);
          sat_d  = 1'b0;
        end
      end

      default: begin
        state_d   = REPOSO;
        cs_n_d    = 1'b1;
        sclk_d    = 1'b0;
        ocupado_d = 1'b0;
      end
    endcase

    // Capture sdo on the same edge that drives sclk from low to high.
    if (sclk_d && !sclk_q) begin
      shift_d = {shift_q[14:0], sdo};
    end
  end

  // State and output registers; reset idles the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= REPOSO;
      timer_q    <= 32'd0;
      div_cnt_q  <= 8'd0;
      half_cnt_q <= 5'd0;
      shift_q    <= 16'd0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      temp_q     <= 11'sd0;
      valido_q   <= 1'b0;
      sat_q      <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_cnt_q  <= div_cnt_d;
      half_cnt_q <= half_cnt_d;
      shift_q    <= shift_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      temp_q     <= temp_d;
      valido_q   <= valido_d;
      sat_q      <= sat_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign sclk         = sclk_q;
  assign cs_n         = cs_n_q;
  assign temp_entrada = temp_q;
  assign dato_valido  = valido_q;
  assign saturado     = sat_q;
  assign ocupado      = ocupado_q;

endmodule

// File: doc/lector_sensor_temp.md
LECTOR_SENSOR_TEMP -- requirements
Module: lector_sensor_temp

Interface
REQ-001 Parameter DIV_SCLK, default 4: clk cycles per sclk half-period; legal range 2..255.
REQ-002 Parameter PERIODO_MUESTREO, default 100000: clk cycles from the end of one conversion to the start of the next automatic one; legal range >=2.
REQ-003 Port clk, input, 1: single clock for all logic, rising-edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port iniciar, input, 1: on-demand conversion request, level-sampled.
REQ-006 Port sdo, input, 1: serial data from the sensor, MSB first.
REQ-007 Port sclk, output, 1: serial clock to the sensor, idle low.
REQ-008 Port cs_n, output, 1: sensor chip select, active low.
REQ-009 Port temp_entrada, output, signed 11: last temperature in tenths of degC (250 = 25.0 degC), feeding comparador range logic.
REQ-010 Port dato_valido, output, 1: one-cycle strobe when temp_entrada updates.
REQ-011 Port saturado, output, 1: the last conversion was clamped; valid with temp_entrada.
REQ-012 Port ocupado, output, 1: high in every state except REPOSO.

Function
REQ-013 FSM states SHALL be REPOSO, SELECCION, TRANSFERENCIA, CONVERSION; every output SHALL be registered.
REQ-014 REPOSO: free-running timer increments each cycle; when timer==PERIODO_MUESTREO-1 or iniciar==1, the next state SHALL be SELECCION and the timer SHALL clear to 0.
REQ-015 SELECCION: cs_n=0, sclk=0 for exactly DIV_SCLK cycles, then TRANSFERENCIA.
REQ-016 TRANSFERENCIA: sclk SHALL toggle every DIV_SCLK cycles, starting low, for exactly 16 full periods (32 half-periods), then end low.
REQ-017 sdo SHALL be shifted into a 16-bit register, MSB first, on the clk edge at which sclk goes 0->1; 16 samples per frame.
REQ-018 After the final low half-period, the state SHALL be CONVERSION with cs_n=1; cs_n low duration per frame = 33*DIV_SCLK cycles.
REQ-019 Frame format: bits[15:3] = raw signed 13-bit temperature in 1/16 degC; bits[2:0] ignored.
REQ-020 Conversion: t = floor(raw*10/16), computed as ((raw<<3)+(raw<<1)) arithmetic-shifted right by 4 in >=17-bit signed width (floor toward minus infinity).
REQ-021 Saturation: t>1023 -> 1023, t<-1024 -> -1024, saturado=1; otherwise saturado=0.
REQ-022 CONVERSION lasts 1 cycle; on its exit edge temp_entrada and saturado SHALL update and dato_valido SHALL be 1 for exactly that next cycle, with the state returning to REPOSO.
REQ-023 iniciar asserted while ocupado=1 SHALL be ignored (not queued); iniciar held high continuously SHALL produce back-to-back conversions separated by 1 REPOSO cycle.
REQ-024 temp_entrada and saturado SHALL hold their values between strobes.
REQ-025 Simultaneous timer expiry and iniciar SHALL start a single conversion.

Reset
REQ-026 While rst=1: state=REPOSO, timer=0, shift register=0, cs_n=1, sclk=0, temp_entrada=0, dato_valido=0, saturado=0, ocupado=0.
REQ-027 rst asserted mid-frame SHALL immediately deassert cs_n and force sclk low; no dato_valido SHALL be emitted for the aborted frame.
REQ-028 After rst release, the first automatic conversion SHALL start PERIODO_MUESTREO cycles later unless iniciar is asserted earlier.

Verification
REQ-029 DIV_SCLK=4, iniciar pulse, sensor model drives 0x0C80 (raw 400) -> cs_n low 132 cycles, 16 sclk rising edges, temp_entrada=250, saturado=0, one dato_valido pulse.
REQ-030 Frame 0xFFF8 (raw -1) -> temp_entrada=-1; frame for raw -880 (0xE480) -> temp_entrada=-550, saturado=0.
REQ-031 Raw 2000 (frame 0x3E80) -> temp_entrada=1023, saturado=1; raw -4096 (frame 0x8000) -> temp_entrada=-1024, saturado=1.
REQ-032 PERIODO_MUESTREO=50, iniciar=0 -> conversions start every 50 REPOSO cycles; iniciar pulsed during TRANSFERENCIA -> no extra frame.
REQ-033 rst pulsed at the 8th sclk rising edge -> cs_n=1 and sclk=0 on the same cycle, no dato_valido, temp_entrada=0; the next iniciar produces a correct full frame.
REQ-034 Bits[2:0] of the frame set to 111 versus 000 with the same raw value -> identical temp_entrada.
